// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard/stall request and pipeline-control bundle for pipe_ctrl.
//   master: pipeline side, drives hazard/ready/redirect/halt requests and
//           receives the PC and pipeline-register controls.
//   slave : pipe_ctrl side.
//   Requests : data_stall_flag, imem_ready, dmem_req, dmem_ready,
//              redirect_valid, redirect_pc[31:0], halt_req
//   Controls : pc_we, pc_sel, redirect_tgt[31:0], *_we enables, *_flush bubbles
interface pipe_ctrl_if;
    logic        data_stall_flag;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;

    logic        pc_we;
    logic        pc_sel;
    logic [31:0] redirect_tgt;
    logic        if_id_we;
    logic        id_exe_we;
    logic        exe_mem_we;
    logic        mem_wb_we;
    logic        if_id_flush;
    logic        id_exe_flush;
    logic        mem_wb_flush;

    modport master (
        output data_stall_flag, imem_ready, dmem_req, dmem_ready,
               redirect_valid, redirect_pc, halt_req,
        input  pc_we, pc_sel, redirect_tgt, if_id_we, id_exe_we, exe_mem_we,
               mem_wb_we, if_id_flush, id_exe_flush, mem_wb_flush
    );

    modport slave (
        input  data_stall_flag, imem_ready, dmem_req, dmem_ready,
               redirect_valid, redirect_pc, halt_req,
        output pc_we, pc_sel, redirect_tgt, if_id_we, id_exe_we, exe_mem_we,
               mem_wb_we, if_id_flush, id_exe_flush, mem_wb_flush
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush/redirect controller.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   bus          : pipe_ctrl_if.slave (hazard requests in, stage controls out)
//   ctrl_state   : BOOT=0, RUN=1, REDIR_PEND=2, HALT=3
//   stall_cycles : saturating count of RUN/REDIR_PEND cycles with pc_we=0
//   flush_events : wrapping count of accepted redirects
// Stage controls are combinational from state and requests. Priority in
// RUN/REDIR_PEND: halt, memory wait, redirect, data stall, fetch wait.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
);
    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        REDIR_PEND = 2'd2,
        HALT       = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] stall_q, stall_d;
    logic [15:0] fev_q, fev_d;

    logic mem_wait;
    logic pc_we_c, pc_sel_c, tgt_live_c;
    logic if_id_we_c, id_exe_we_c, exe_mem_we_c, mem_wb_we_c;
    logic if_id_fl_c, id_exe_fl_c, mem_wb_fl_c;

    assign mem_wait = bus.dmem_req & ~bus.dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            tgt_q   <= '0;
            stall_q <= '0;
            fev_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            stall_q <= stall_d;
            fev_q   <= fev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        fev_d   = fev_q;
        stall_d = stall_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.halt_req) begin
                    state_d = HALT;
                end else if (!mem_wait && bus.redirect_valid) begin
                    tgt_d = bus.redirect_pc;
                    fev_d = fev_q + 16'd1;
                    if (!bus.imem_ready) state_d = REDIR_PEND;
                end
            end
            REDIR_PEND: begin
                if (bus.halt_req)                    state_d = HALT;
                else if (!mem_wait && bus.imem_ready) state_d = RUN;
            end
            HALT: state_d = HALT;
        endcase
        if ((state_q == RUN || state_q == REDIR_PEND) && !pc_we_c && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end

    always_comb begin
        pc_we_c      = 1'b0;
        pc_sel_c     = 1'b0;
        tgt_live_c   = 1'b0;
        if_id_we_c   = 1'b0;
        id_exe_we_c  = 1'b0;
        exe_mem_we_c = 1'b0;
        mem_wb_we_c  = 1'b0;
        if_id_fl_c   = 1'b0;
        id_exe_fl_c  = 1'b0;
        mem_wb_fl_c  = 1'b0;
        unique case (state_q)
            BOOT: begin
                if_id_fl_c  = 1'b1;
                id_exe_fl_c = 1'b1;
                mem_wb_fl_c = 1'b1;
            end
            HALT: ;
            RUN, REDIR_PEND: begin
                if (!bus.halt_req) begin
                    if_id_we_c   = 1'b1;
                    id_exe_we_c  = 1'b1;
                    exe_mem_we_c = 1'b1;
                    mem_wb_we_c  = 1'b1;
                    if (mem_wait) begin
                        // EXE is frozen so any redirect it raises is retried later.
                        if_id_we_c   = 1'b0;
                        id_exe_we_c  = 1'b0;
                        exe_mem_we_c = 1'b0;
                        mem_wb_fl_c  = 1'b1;
                        if (state_q == REDIR_PEND) if_id_fl_c = 1'b1;
                    end else if (state_q == REDIR_PEND) begin
                        // ID/EXE hold only bubbles here, so redirects and data
                        // stalls are not acted on; the fetched word is dropped.
                        if_id_fl_c = 1'b1;
                        if (bus.imem_ready) begin
                            pc_we_c  = 1'b1;
                            pc_sel_c = 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        if_id_fl_c  = 1'b1;
                        id_exe_fl_c = 1'b1;
                        if (bus.imem_ready) begin
                            pc_we_c    = 1'b1;
                            pc_sel_c   = 1'b1;
                            tgt_live_c = 1'b1;
                        end
                    end else if (bus.data_stall_flag) begin
                        if_id_we_c  = 1'b0;
                        id_exe_fl_c = 1'b1;
                    end else if (!bus.imem_ready) begin
                        if_id_fl_c = 1'b1;
                    end else begin
                        pc_we_c = 1'b1;
                    end
                end
            end
        endcase
    end

    // A flushed register loads the bubble, so its enable is masked off.
    assign bus.pc_we        = pc_we_c;
    assign bus.pc_sel       = pc_sel_c;
    assign bus.redirect_tgt = tgt_live_c ? bus.redirect_pc : tgt_q;
    assign bus.if_id_we     = if_id_we_c & ~if_id_fl_c;
    assign bus.id_exe_we    = id_exe_we_c & ~id_exe_fl_c;
    assign bus.exe_mem_we   = exe_mem_we_c;
    assign bus.mem_wb_we    = mem_wb_we_c & ~mem_wb_fl_c;
    assign bus.if_id_flush  = if_id_fl_c;
    assign bus.id_exe_flush = id_exe_fl_c;
    assign bus.mem_wb_flush = mem_wb_fl_c;

    assign ctrl_state   = state_q;
    assign stall_cycles = stall_q;
    assign flush_events = fev_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. Each cycle the driven inputs
// are run through a reference model whose expected outputs are queued, then
// popped and compared against the DUT on the falling edge.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic        pc_we;
        logic        pc_sel;
        logic [31:0] tgt;
        logic [3:0]  we;   // {if_id, id_exe, exe_mem, mem_wb}
        logic [2:0]  fl;   // {if_id, id_exe, mem_wb}
        logic [31:0] stall;
        logic [15:0] fev;
    } exp_t;

    exp_t sb_q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [1:0]  m_st, n_st;
    logic [31:0] m_tgt, n_tgt, m_stall, n_stall;
    logic [15:0] m_fev, n_fev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval(input logic ds, ir, dq, dr, rv, hr,
                              input logic [31:0] rpc, output exp_t e);
        logic mw;
        mw = dq && !dr;
        e.st = m_st; e.tgt = m_tgt; e.stall = m_stall; e.fev = m_fev;
        e.pc_we = 1'b0; e.pc_sel = 1'b0; e.we = 4'b0000; e.fl = 3'b000;
        n_st = m_st; n_tgt = m_tgt; n_fev = m_fev; n_stall = m_stall;
        if (m_st == 2'd0) begin
            e.fl = 3'b111;
            n_st = 2'd1;
        end else if (m_st == 2'd1 || m_st == 2'd2) begin
            if (hr) begin
                n_st = 2'd3;
            end else if (mw) begin
                e.fl = (m_st == 2'd2) ? 3'b101 : 3'b001;
            end else if (m_st == 2'd2) begin
                e.we = 4'b0111; e.fl = 3'b100;
                if (ir) begin e.pc_we = 1'b1; e.pc_sel = 1'b1; n_st = 2'd1; end
            end else if (rv) begin
                e.we = 4'b0011; e.fl = 3'b110;
                n_tgt = rpc; n_fev = m_fev + 16'd1;
                if (ir) begin e.pc_we = 1'b1; e.pc_sel = 1'b1; e.tgt = rpc; end
                else n_st = 2'd2;
            end else if (ds) begin
                e.we = 4'b0011; e.fl = 3'b010;
            end else if (!ir) begin
                e.we = 4'b0111; e.fl = 3'b100;
            end else begin
                e.pc_we = 1'b1; e.we = 4'b1111;
            end
            if (!e.pc_we && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 32'd1;
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        logic [3:0] we;
        logic [2:0] fl;
        e = sb_q.pop_front();
        we = {bus.if_id_we, bus.id_exe_we, bus.exe_mem_we, bus.mem_wb_we};
        fl = {bus.if_id_flush, bus.id_exe_flush, bus.mem_wb_flush};
        chk({tag, ".state"}, 32'(ctrl_state), 32'(e.st));
        chk({tag, ".pc_we"}, 32'(bus.pc_we), 32'(e.pc_we));
        chk({tag, ".pc_sel"}, 32'(bus.pc_sel), 32'(e.pc_sel));
        chk({tag, ".tgt"}, bus.redirect_tgt, e.tgt);
        chk({tag, ".we"}, 32'(we), 32'(e.we));
        chk({tag, ".flush"}, 32'(fl), 32'(e.fl));
        chk({tag, ".stall_cycles"}, stall_cycles, e.stall);
        chk({tag, ".flush_events"}, 32'(flush_events), 32'(e.fev));
    endtask

    // Called at posedge+1: drive, predict, check at negedge, advance model at next edge.
    task automatic step(input string tag, input logic ds, ir, dq, dr, rv, hr,
                        input logic [31:0] rpc);
        exp_t e;
        bus.data_stall_flag = ds; bus.imem_ready = ir; bus.dmem_req = dq;
        bus.dmem_ready = dr; bus.redirect_valid = rv; bus.halt_req = hr;
        bus.redirect_pc = rpc;
        model_eval(ds, ir, dq, dr, rv, hr, rpc, e);
        sb_q.push_back(e);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
        m_st = n_st; m_tgt = n_tgt; m_stall = n_stall; m_fev = n_fev;
    endtask

    task automatic idle(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(tag, 0, 1, 0, 0, 0, 0, 32'h0);
    endtask

    // Asynchronous reset pulse, checked before any clock edge sees it.
    task automatic do_reset(input string tag);
        exp_t e;
        rst_n = 1'b0;
        #1;
        m_st = 2'd0; m_tgt = '0; m_stall = '0; m_fev = '0;
        e.st = 2'd0; e.pc_we = 1'b0; e.pc_sel = 1'b0; e.tgt = '0;
        e.we = 4'b0000; e.fl = 3'b111; e.stall = '0; e.fev = '0;
        sb_q.push_back(e);
        compare(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.data_stall_flag = 0; bus.imem_ready = 1; bus.dmem_req = 0;
        bus.dmem_ready = 0; bus.redirect_valid = 0; bus.halt_req = 0;
        bus.redirect_pc = '0;
        m_st = 2'd0; m_tgt = '0; m_stall = '0; m_fev = '0;
        n_st = 2'd0; n_tgt = '0; n_stall = '0; n_fev = '0;
        #2;
        do_reset("reset");
        idle("boot_run", 4);

        step("dstall0", 1, 1, 0, 0, 0, 0, 32'h0);
        step("dstall1", 1, 1, 0, 0, 0, 0, 32'h0);
        idle("after_dstall", 2);

        step("redir_now", 0, 1, 0, 0, 1, 0, 32'h0000_0100);
        idle("after_redir", 1);

        step("redir_pend_acc", 0, 0, 0, 0, 1, 0, 32'h0000_0200);
        for (int unsigned i = 0; i < 3; i++)
            step("redir_pend", 0, 0, 0, 0, 1, 0, 32'h0000_0999);
        step("redir_pend_done", 0, 1, 0, 0, 0, 0, 32'h0);
        idle("after_pend", 2);

        step("memwait0", 1, 1, 1, 0, 1, 0, 32'h0000_0300);
        step("memwait1", 1, 1, 1, 0, 1, 0, 32'h0000_0300);
        step("memdone_redir", 1, 1, 1, 1, 1, 0, 32'h0000_0300);
        step("fetchwait", 0, 0, 0, 0, 0, 0, 32'h0);
        step("fetchwait", 0, 0, 1, 1, 0, 0, 32'h0);
        idle("after_fetch", 1);

        step("pend_memwait_acc", 0, 0, 0, 0, 1, 0, 32'h0000_0400);
        step("pend_memwait", 0, 1, 1, 0, 0, 0, 32'h0);
        do_reset("reset_in_pend");
        idle("boot_again", 3);

        for (int unsigned i = 0; i < 300; i++)
            step("random", 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'b0, $urandom);

        step("halt_req", 0, 1, 0, 0, 1, 1, 32'h0000_0500);
        for (int unsigned i = 0; i < 3; i++)
            step("halt_hold", 1, 0, 1, 0, 1, 0, 32'h0000_0600);
        do_reset("reset_in_halt");
        idle("boot_after_halt", 2);

        // flush_events crosses 16'hFFFF -> 0 within this run of redirects.
        for (int unsigned i = 0; i < 65540; i++)
            step("fev_wrap", 0, 1, 0, 0, 1, 0, i);
        idle("after_wrap", 1);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d leftover expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
